// File: rtl/imem_pkg.sv
// imem_pkg
//    Shared definitions for the loadable instruction memory: the controller
//    state encoding and the default word returned for unserviceable fetches.
package imem_pkg;

   // Controller states: no program present, program streaming in, serving fetches
   typedef enum logic [1:0] {
      EMPTY   = 2'd0,
      LOADING = 2'd1,
      RUN     = 2'd2
   } imem_state_t;

   // Default word returned for out-of-range or faulted fetches
   localparam logic [31:0] IMEM_NOP_WORD = 32'h0000_0000;

endpackage : imem_pkg

// File: rtl/imem_array.sv
// imem_array
//    Single-write / single-read synchronous RAM, DEPTH x DATA_W, with a
//    registered read port (one cycle latency). Contents are never cleared;
//    only the read register is reset so the fetch output starts at zero.
// Ports
//    i_clock    : rising-edge clock
//    i_reset_n  : synchronous active-low reset (read register only)
//    i_wr_en    : write strobe
//    i_wr_idx   : write index
//    i_wr_data  : write data
//    i_rd_en    : read strobe; o_rd_data updates on the next edge
//    i_rd_idx   : read index (must be < DEPTH when i_rd_en is high)
//    o_rd_data  : registered read data, holds when i_rd_en is low
module imem_array #(
   parameter int DEPTH  = 150,
   parameter int DATA_W = 32,
   parameter int IDX_W  = 8
) (
   input  logic              i_clock,
   input  logic              i_reset_n,
   input  logic              i_wr_en,
   input  logic [IDX_W-1:0]  i_wr_idx,
   input  logic [DATA_W-1:0] i_wr_data,
   input  logic              i_rd_en,
   input  logic [IDX_W-1:0]  i_rd_idx,
   output logic [DATA_W-1:0] o_rd_data
);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_rd_data;

   // Storage write port; the array itself has no reset
   always_ff @(posedge i_clock) begin
      if (i_wr_en) begin
         r_mem[i_wr_idx] <= i_wr_data;
      end
   end

   // Registered read port, holds its value between reads
   always_ff @(posedge i_clock) begin
      if (!i_reset_n) begin
         r_rd_data <= {DATA_W{1'b0}};
      end else if (i_rd_en) begin
         r_rd_data <= r_mem[i_rd_idx];
      end else begin
         r_rd_data <= r_rd_data;
      end
   end

   assign o_rd_data = r_rd_data;

endmodule : imem_array

// File: rtl/imem_loadable.sv
// imem_loadable
//    Loadable instruction memory for the fetch stage. A program is streamed in
//    over the load port (EMPTY -> LOADING -> RUN), then served over a
//    valid/ready fetch port with exactly one cycle of read latency.
//    Build option: define IMEM_BOUNDS_CHECK_EN to make fetches at or beyond the
//    loaded word count return NOP_WORD and pulse fetch_fault; otherwise
//    fetch_fault is constant 0 and only addresses >= DEPTH return NOP_WORD.
// Ports
//    clock, reset_n           : clock, synchronous active-low reset
//    load_start               : begin (or restart) a program load
//    load_valid/data/last     : load word stream; last marks the final word
//    load_ready               : load words accepted this cycle
//    load_count               : words written in the current/last load
//    fetch_req/fetch_addr     : fetch request and word address
//    fetch_ready              : fetch requests accepted this cycle
//    inst_valid/instruction   : one-cycle pulse per accepted fetch, with data
//    fetch_fault              : accepted fetch was outside the loaded program
module imem_loadable
   import imem_pkg::*;
#(
   parameter int                ADDR_W   = 20,
   parameter int                DATA_W   = 32,
   parameter int                DEPTH    = 150,
   parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(IMEM_NOP_WORD)
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              load_start,
   input  logic              load_valid,
   input  logic [DATA_W-1:0] load_data,
   input  logic              load_last,
   output logic              load_ready,
   output logic [ADDR_W-1:0] load_count,
   input  logic              fetch_req,
   input  logic [ADDR_W-1:0] fetch_addr,
   output logic              fetch_ready,
   output logic              inst_valid,
   output logic [DATA_W-1:0] instruction,
   output logic              fetch_fault
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   imem_state_t       r_state;
   imem_state_t       w_state_next;
   logic [ADDR_W-1:0] r_wr_ptr;
   logic              r_load_ready;
   logic              r_fetch_ready;
   logic              r_inst_valid;
   logic              r_nop;
   logic              r_fetch_fault;
   logic              w_load_acc;
   logic              w_ptr_at_end;
   logic              w_fetch_acc;
   logic              w_addr_oob;
   logic              w_fault;
   logic              w_nop;
   logic [DATA_W-1:0] w_rd_data;

   // A restart wins over a word presented in the same cycle; that word is dropped
   assign w_load_acc   = load_valid && r_load_ready && !load_start;
   assign w_ptr_at_end = (r_wr_ptr == ADDR_W'(DEPTH - 1));
   assign w_fetch_acc  = fetch_req && r_fetch_ready;
   assign w_addr_oob   = (fetch_addr >= ADDR_W'(DEPTH));

`ifdef IMEM_BOUNDS_CHECK_EN
   assign w_fault = (fetch_addr >= r_wr_ptr);
`else
   assign w_fault = 1'b0;
`endif

   assign w_nop = w_addr_oob || w_fault;

   // Next-state logic for the load/run controller
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         EMPTY: begin
            if (load_start) begin
               w_state_next = LOADING;
            end else begin
               w_state_next = EMPTY;
            end
         end
         LOADING: begin
            if (load_start) begin
               w_state_next = LOADING;
            end else if (w_load_acc && (load_last || w_ptr_at_end)) begin
               w_state_next = RUN;
            end else begin
               w_state_next = LOADING;
            end
         end
         RUN: begin
            if (load_start) begin
               w_state_next = LOADING;
            end else begin
               w_state_next = RUN;
            end
         end
         default: begin
            w_state_next = EMPTY;
         end
      endcase
   end

   // State register plus ready flags; the flags are decoded from the next
   // state so they always agree with the state register
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_state       <= EMPTY;
         r_load_ready  <= 1'b0;
         r_fetch_ready <= 1'b0;
      end else begin
         r_state       <= w_state_next;
         r_load_ready  <= (w_state_next == LOADING);
         r_fetch_ready <= (w_state_next == RUN);
      end
   end

   // Write pointer; it doubles as the loaded word count
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_wr_ptr <= {ADDR_W{1'b0}};
      end else if (load_start) begin
         r_wr_ptr <= {ADDR_W{1'b0}};
      end else if (w_load_acc) begin
         r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      end else begin
         r_wr_ptr <= r_wr_ptr;
      end
   end

   // Fetch response flags, captured on the accepting edge alongside the RAM read
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_inst_valid  <= 1'b0;
         r_nop         <= 1'b0;
         r_fetch_fault <= 1'b0;
      end else begin
         r_inst_valid  <= w_fetch_acc;
         r_fetch_fault <= w_fetch_acc && w_fault;
         if (w_fetch_acc) begin
            r_nop <= w_nop;
         end else begin
            r_nop <= r_nop;
         end
      end
   end

   // Out-of-range reads are never issued to the RAM, so its index stays in bounds
   imem_array #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W),
      .IDX_W  (IDX_W)
   ) u_array (
      .i_clock   (clock),
      .i_reset_n (reset_n),
      .i_wr_en   (w_load_acc),
      .i_wr_idx  (r_wr_ptr[IDX_W-1:0]),
      .i_wr_data (load_data),
      .i_rd_en   (w_fetch_acc && !w_addr_oob),
      .i_rd_idx  (fetch_addr[IDX_W-1:0]),
      .o_rd_data (w_rd_data)
   );

   assign load_ready  = r_load_ready;
   assign load_count  = r_wr_ptr;
   assign fetch_ready = r_fetch_ready;
   assign inst_valid  = r_inst_valid;
   // Both mux inputs are registers that only change on an accepted fetch,
   // so the word holds while inst_valid is low
   assign instruction = r_nop ? NOP_WORD : w_rd_data;
   assign fetch_fault = r_fetch_fault;

endmodule : imem_loadable
